// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

   // Arbiter FSM: free arbitration, or a lock held by port 0 / port 1
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   // Port identifiers as stored in the round-robin pointer
   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_EXT = 1'b1;

   // Byte-enable patterns
   localparam logic [3:0] WE_NONE = 4'b0000;
   localparam logic [3:0] WE_WORD = 4'b1111;

   // An access with no byte enables is a read
   function automatic logic is_read(input logic [3:0] we);
      return (we == WE_NONE);
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin selector: on contention the port that was not
// granted last wins; a lone requester always wins.
module rr_pick2
   import dmem_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   // Pure combinational pick based on the request pattern and the pointer
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11: begin
            if (last == PORT_CPU) begin
               gnt = 2'b10;
            end else begin
               gnt = 2'b01;
            end
         end
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-ported byte-writable data memory between the CPU data
// port (port 0) and an external master (port 1). Round-robin fairness with a
// bounded lock for back-to-back accesses; read data returns one cycle later.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int MAX_LOCK = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [31:0]       m0_wdata,
   input  logic [3:0]        m0_we,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [31:0]       m0_rdata,
   input  logic              m1_req,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   input  logic [3:0]        m1_we,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [31:0]       m1_rdata,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_we,
   input  logic [31:0]       mem_rdata
);

   localparam int                 LCNT_W   = $clog2(MAX_LOCK + 1);
   localparam logic [LCNT_W-1:0]  LCNT_MAX = LCNT_W'(MAX_LOCK);
   localparam logic [LCNT_W-1:0]  LCNT_ONE = LCNT_W'(1);
   localparam logic [LCNT_W-1:0]  LCNT_ZERO = {LCNT_W{1'b0}};
   // With a bound of one the first grant already exhausts the lock
   localparam logic               LOCK_EN  = (MAX_LOCK > 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_last;
   logic               w_last_nxt;
   logic [LCNT_W-1:0]  r_lcnt;
   logic [LCNT_W-1:0]  w_lcnt_nxt;
   logic [LCNT_W-1:0]  w_lcnt_inc;
   logic [1:0]         r_rvalid;
   logic [1:0]         w_rvalid_nxt;
   logic [1:0]         w_req;
   logic [1:0]         w_rr_gnt;
   logic [1:0]         w_gnt;
   logic               w_idle_arb;

   assign w_req = {m1_req, m0_req};

   rr_pick2 u_pick (
      .req  (w_req),
      .last (r_last),
      .gnt  (w_rr_gnt)
   );

   // Next-state, grant and lock-counter logic
   always_comb begin
      w_gnt       = 2'b00;
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_lcnt_nxt  = r_lcnt;
      w_lcnt_inc  = r_lcnt + LCNT_ONE;
      w_idle_arb  = 1'b0;
      if (reset) begin
         w_gnt = 2'b00;
      end else begin
         case (r_state)
            IDLE: begin
               w_idle_arb = 1'b1;
            end
            LOCK0: begin
               if (m0_req) begin
                  w_gnt      = 2'b01;
                  w_last_nxt = PORT_CPU;
                  if (!m0_lock || (w_lcnt_inc == LCNT_MAX)) begin
                     w_state_nxt = IDLE;
                     w_lcnt_nxt  = LCNT_ZERO;
                  end else begin
                     w_lcnt_nxt  = w_lcnt_inc;
                  end
               end else begin
                  // Holder walked away: arbitrate normally this very cycle
                  w_state_nxt = IDLE;
                  w_lcnt_nxt  = LCNT_ZERO;
                  w_idle_arb  = 1'b1;
               end
            end
            LOCK1: begin
               if (m1_req) begin
                  w_gnt      = 2'b10;
                  w_last_nxt = PORT_EXT;
                  if (!m1_lock || (w_lcnt_inc == LCNT_MAX)) begin
                     w_state_nxt = IDLE;
                     w_lcnt_nxt  = LCNT_ZERO;
                  end else begin
                     w_lcnt_nxt  = w_lcnt_inc;
                  end
               end else begin
                  w_state_nxt = IDLE;
                  w_lcnt_nxt  = LCNT_ZERO;
                  w_idle_arb  = 1'b1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_lcnt_nxt  = LCNT_ZERO;
            end
         endcase

         if (w_idle_arb) begin
            w_gnt = w_rr_gnt;
            if (w_rr_gnt[0]) begin
               w_last_nxt = PORT_CPU;
               if (m0_lock && LOCK_EN) begin
                  w_state_nxt = LOCK0;
                  w_lcnt_nxt  = LCNT_ONE;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else if (w_rr_gnt[1]) begin
               w_last_nxt = PORT_EXT;
               if (m1_lock && LOCK_EN) begin
                  w_state_nxt = LOCK1;
                  w_lcnt_nxt  = LCNT_ONE;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               w_last_nxt = r_last;
            end
         end else begin
            w_idle_arb = 1'b0;
         end
      end
   end

   // Memory request mux: granted port's signals, all zero when idle
   always_comb begin
      mem_en    = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = 32'h0000_0000;
      mem_we    = WE_NONE;
      if (w_gnt[0]) begin
         mem_en    = 1'b1;
         mem_addr  = m0_addr;
         mem_wdata = m0_wdata;
         mem_we    = m0_we;
      end else if (w_gnt[1]) begin
         mem_en    = 1'b1;
         mem_addr  = m1_addr;
         mem_wdata = m1_wdata;
         mem_we    = m1_we;
      end else begin
         mem_en    = 1'b0;
      end
   end

   // Reads granted this cycle return next cycle to their owner
   always_comb begin
      w_rvalid_nxt = {w_gnt[1] & is_read(m1_we), w_gnt[0] & is_read(m0_we)};
   end

   // Read data steering: only the owning port sees memory data
   always_comb begin
      m0_rdata = 32'h0000_0000;
      m1_rdata = 32'h0000_0000;
      if (r_rvalid[0]) begin
         m0_rdata = mem_rdata;
      end else if (r_rvalid[1]) begin
         m1_rdata = mem_rdata;
      end else begin
         m0_rdata = 32'h0000_0000;
      end
   end

   assign m0_gnt    = w_gnt[0];
   assign m1_gnt    = w_gnt[1];
   assign m0_rvalid = r_rvalid[0];
   assign m1_rvalid = r_rvalid[1];

   // State, round-robin pointer, lock counter and read-return registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_last   <= PORT_EXT;
         r_lcnt   <= LCNT_ZERO;
         r_rvalid <= 2'b00;
      end else begin
         r_state  <= w_state_nxt;
         r_last   <= w_last_nxt;
         r_lcnt   <= w_lcnt_nxt;
         r_rvalid <= w_rvalid_nxt;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter (MAX_LOCK=3) with a small
// synchronous byte-writable memory model behind the arbiter.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_lock, m1_req, m1_lock;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_we, m1_we;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_en;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_we;
   logic [31:0] mem_rdata = 32'h0;

   typedef struct {
      logic [1:0]  gnt;
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
      logic [1:0]  rv;
   } cyc_t;

   typedef struct {
      logic        port;
      logic [31:0] data;
   } rd_t;

   cyc_t cq[$];
   rd_t  rq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [31:0] mem [256];
   logic        mem_ready = 1'b0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(32), .MAX_LOCK(3)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_gnt(m0_gnt),
      .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_gnt(m1_gnt),
      .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   // Memory model: word i holds 0x1000_0000+i, word 0x10 holds 0xDEADBEEF
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + i;
         mem[16]   <= 32'hDEAD_BEEF;
         mem_ready <= 1'b1;
      end else if (mem_en) begin
         if (mem_we == 4'b0000) begin
            mem_rdata <= mem[mem_addr[9:2]];
         end else begin
            for (int b = 0; b < 4; b++)
               if (mem_we[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: per-cycle grant/memory drive check and read-return check
   always @(negedge clk) begin
      if (cq.size() > 0) begin
         cyc_t e;
         e = cq.pop_front();
         check("gnt",       {30'd0, m1_gnt, m0_gnt},       {30'd0, e.gnt});
         check("mem_en",    {31'd0, mem_en},               {31'd0, |e.gnt});
         check("mem_addr",  mem_addr,                      e.addr);
         check("mem_we",    {28'd0, mem_we},               {28'd0, e.we});
         check("mem_wdata", mem_wdata,                     e.wdata);
         check("rvalid",    {30'd0, m1_rvalid, m0_rvalid}, {30'd0, e.rv});
      end
      if (m0_rvalid || m1_rvalid) begin
         if (rq.size() == 0) begin
            check("rvalid_unexpected", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
         end else begin
            rd_t r;
            r = rq.pop_front();
            check("rdata_owner", r.port ? m1_rdata : m0_rdata, r.data);
            check("rdata_other", r.port ? m0_rdata : m1_rdata, 32'h0);
         end
      end
   end

   task automatic set_m0(input logic req, input logic lock, input logic [31:0] addr,
                         input logic [3:0] we, input logic [31:0] wdata);
      m0_req = req; m0_lock = lock; m0_addr = addr; m0_we = we; m0_wdata = wdata;
   endtask

   task automatic set_m1(input logic req, input logic lock, input logic [31:0] addr,
                         input logic [3:0] we, input logic [31:0] wdata);
      m1_req = req; m1_lock = lock; m1_addr = addr; m1_we = we; m1_wdata = wdata;
   endtask

   task automatic idle();
      set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      set_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   // One cycle: expected grant, expected rvalid this cycle, data for a read granted now
   task automatic step(input logic [1:0] eg, input logic [1:0] erv, input logic [31:0] erd);
      cyc_t c;
      rd_t  r;
      c.gnt = eg; c.rv = erv;
      c.addr = 32'h0; c.we = 4'h0; c.wdata = 32'h0;
      if (eg == 2'b01) begin
         c.addr = m0_addr; c.we = m0_we; c.wdata = m0_wdata;
         if (m0_we == 4'h0) begin r.port = 1'b0; r.data = erd; rq.push_back(r); end
      end else if (eg == 2'b10) begin
         c.addr = m1_addr; c.we = m1_we; c.wdata = m1_wdata;
         if (m1_we == 4'h0) begin r.port = 1'b1; r.data = erd; rq.push_back(r); end
      end
      cq.push_back(c);
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      @(posedge clk); #1;
      // Held in reset with a read request: no grant, no memory activity
      set_m0(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
      step(2'b00, 2'b00, 32'h0);
      step(2'b00, 2'b00, 32'h0);
      reset = 1'b0;

      // Solo read
      step(2'b01, 2'b00, 32'hDEAD_BEEF);
      idle();
      step(2'b00, 2'b01, 32'h0);

      // Contention right after reset: 0,1,0,1
      reset = 1'b1;
      step(2'b00, 2'b00, 32'h0);
      reset = 1'b0;
      set_m0(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
      set_m1(1'b1, 1'b0, 32'h44, 4'h0, 32'h0);
      step(2'b01, 2'b00, 32'hDEAD_BEEF);
      step(2'b10, 2'b01, 32'h1000_0011);
      step(2'b01, 2'b10, 32'hDEAD_BEEF);
      step(2'b10, 2'b01, 32'h1000_0011);
      idle();
      step(2'b00, 2'b10, 32'h0);

      // Lock bound of 3 held by port 1
      set_m1(1'b1, 1'b1, 32'h48, 4'h0, 32'h0);
      step(2'b10, 2'b00, 32'h1000_0012);
      set_m0(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
      step(2'b10, 2'b10, 32'h1000_0012);
      step(2'b10, 2'b10, 32'h1000_0012);
      step(2'b01, 2'b10, 32'hDEAD_BEEF);
      set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      set_m1(1'b1, 1'b0, 32'h48, 4'h0, 32'h0);
      step(2'b10, 2'b01, 32'h1000_0012);
      idle();
      step(2'b00, 2'b10, 32'h0);

      // Lock holder drops req: other port granted the same cycle
      set_m0(1'b1, 1'b1, 32'h40, 4'h0, 32'h0);
      step(2'b01, 2'b00, 32'hDEAD_BEEF);
      set_m1(1'b1, 1'b0, 32'h44, 4'h0, 32'h0);
      step(2'b01, 2'b01, 32'hDEAD_BEEF);
      set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      step(2'b10, 2'b01, 32'h1000_0011);
      idle();
      step(2'b00, 2'b10, 32'h0);

      // Lock released on second grant: port 1 wins the next contention
      set_m0(1'b1, 1'b1, 32'h40, 4'h0, 32'h0);
      step(2'b01, 2'b00, 32'hDEAD_BEEF);
      set_m0(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
      set_m1(1'b1, 1'b0, 32'h44, 4'h0, 32'h0);
      step(2'b01, 2'b01, 32'hDEAD_BEEF);
      set_m0(1'b1, 1'b0, 32'h48, 4'h0, 32'h0);
      step(2'b10, 2'b01, 32'h1000_0011);
      set_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      step(2'b01, 2'b10, 32'h1000_0012);
      idle();
      step(2'b00, 2'b01, 32'h0);

      // Byte-lane write from port 1, then read back through port 0
      set_m1(1'b1, 1'b0, 32'h102, 4'b0100, 32'h00AB_0000);
      step(2'b10, 2'b00, 32'h0);
      idle();
      step(2'b00, 2'b00, 32'h0);
      set_m0(1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
      step(2'b01, 2'b00, 32'h10AB_0040);
      idle();
      step(2'b00, 2'b01, 32'h0);

      // Reset in the middle of a port-0 lock
      set_m0(1'b1, 1'b1, 32'h40, 4'h0, 32'h0);
      step(2'b01, 2'b00, 32'hDEAD_BEEF);
      reset = 1'b1;
      step(2'b00, 2'b01, 32'h0);
      reset = 1'b0;
      set_m0(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
      set_m1(1'b1, 1'b0, 32'h44, 4'h0, 32'h0);
      step(2'b01, 2'b00, 32'hDEAD_BEEF);
      set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      step(2'b10, 2'b01, 32'h1000_0011);
      idle();
      step(2'b00, 2'b10, 32'h0);
      step(2'b00, 2'b00, 32'h0);

      check("cycle_queue_drained", cq.size(), 32'd0);
      check("read_queue_drained",  rq.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
